bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_pkg.sv | 12 +
 rtl/fa_dec_cell.sv | 17 +
 rtl/bit_serial_adder.sv | 99 +++++++++
 tb/tb_bit_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_dec_cell.sv
// Combinational 1-bit full adder: 3-to-8 decoder with OR-ed minterms.
module fa_dec_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic [7:0] m;

    // Minterm index is {a, b, ci}.
    assign m  = 8'b1 << {a, b, ci};
    assign s  = m[1] | m[2] | m[4] | m[7];
    assign co = m[3] | m[5] | m[6] | m[7];

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit per clock LSB first, valid/ready on both sides.
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r, out_valid_r, busy_r, init_done;
    logic             fa_s, fa_c, accept;

    // init_done keeps in_ready low during reset and until the first edge after release.
    assign in_ready = init_done && (state == IDLE || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    assign sum       = sum_sh;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

    fa_dec_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (accept) begin
                // accept only occurs in IDLE or DONE, covering the back-to-back case
                a_sh        <= a;
                b_sh        <= b;
                carry       <= cin;
                cnt         <= '0;
                state       <= RUN;
                busy_r      <= 1'b1;
                out_valid_r <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                        a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                        carry  <= fa_c;
                        if (cnt == LAST) begin
                            state       <= DONE;
                            cout_r      <= fa_c;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state       <= IDLE;
                            out_valid_r <= 1'b0;
                        end
                    end
                    IDLE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH = 8.
module tb_bit_serial_adder;

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, sum;
    int         checks = 0;
    int         errors = 0;
    int         lat;
    logic       saw_valid;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept edge; in_ready is expected high going in.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Counts clocks from the accept edge until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);

        // FF + 01: latency exactly 8 clocks
        start_op(8'hFF, 8'h01, 1'b0);
        check("ff_busy", busy, 1);
        check("ff_in_ready_run", in_ready, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("ff_valid_clk%0d", i), out_valid, (i == 8) ? 1 : 0);
        end
        check("ff_sum", sum, 8'h00);
        check("ff_cout", cout, 1);
        check("ff_busy_done", busy, 0);
        check("ff_in_ready_done", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("ff_in_ready_or", in_ready, 1);
        step();
        out_ready = 1'b0;
        check("idle_out_valid", out_valid, 0);
        check("idle_sum_hold", sum, 8'h00);
        check("idle_cout_hold", cout, 1);
        check("idle_in_ready", in_ready, 1);

        // A5 + 5A + 1 = 0x100
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done(lat);
        check("a5_lat", lat, 8);
        check("a5_sum", sum, 8'h00);
        check("a5_cout", cout, 1);
        release_result();

        // 12 + 34 = 46
        start_op(8'h12, 8'h34, 1'b0);
        wait_done(lat);
        check("12_lat", lat, 8);
        check("12_sum", sum, 8'h46);
        check("12_cout", cout, 0);
        release_result();

        // Stall: 7F + 01 = 80, out_ready low for 5 clocks
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(lat);
        check("stall_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_valid%0d", i), out_valid, 1);
            check($sformatf("stall_sum%0d", i), sum, 8'h80);
            check($sformatf("stall_cout%0d", i), cout, 0);
            check($sformatf("stall_in_ready%0d", i), in_ready, 0);
        end
        release_result();

        // in_valid pulsed mid-RUN is ignored: C3 + 3C = FF
        start_op(8'hC3, 8'h3C, 1'b0);
        step(); step();
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 3;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("midrun_lat", lat, 8);
        check("midrun_sum", sum, 8'hFF);
        check("midrun_cout", cout, 0);
        release_result();

        // Back-to-back: 10 + 20 + 1 = 31, then F0 + 0F + 1 = 0x100
        start_op(8'h10, 8'h20, 1'b1);
        wait_done(lat);
        check("b2b1_sum", sum, 8'h31);
        check("b2b1_cout", cout, 0);
        out_ready = 1'b1;
        start_op(8'hF0, 8'h0F, 1'b1);
        out_ready = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_out_valid", out_valid, 0);
        wait_done(lat);
        check("b2b2_lat", lat, 8);
        check("b2b2_sum", sum, 8'h00);
        check("b2b2_cout", cout, 1);
        release_result();

        // Reset at RUN bit 3 aborts the operation
        start_op(8'h55, 8'h0A, 1'b0);
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        check("abort_in_ready_rel", in_ready, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", saw_valid, 0);
        start_op(8'h33, 8'h44, 1'b1);
        wait_done(lat);
        check("after_abort_lat", lat, 8);
        check("after_abort_sum", sum, 8'h78);
        check("after_abort_cout", cout, 0);
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
